// File: rtl/lib_switch_onehot_rr.sv
// Purpose : NxM crossbar; each output has its own round-robin arbiter feeding a registered output word.
// Latency : 1 cycle from o_ack of an input to o_valid of the selected output.
// Backpr. : output j accepts a new word only when empty or drained this cycle (!o_valid[j] || i_en[j]);
//           a stalled output holds data, valid and pointer, and acks nobody.
//
// Ports
//   clk            rising-edge clock
//   reset          asynchronous, active-high reset
//   i_data[i]      input word of input i
//   i_valid[i]     input i presents a word
//   i_dest[i][j]   one-hot (or zero) output request of input i; bit j selects output j
//   o_ack[i]       combinational accept of input i's word this cycle
//   o_data[j]      registered output word of output j
//   o_valid[j]     registered output valid of output j
//   i_en[j]        downstream consumes output j on a cycle with o_valid[j] && i_en[j]
//   o_conflict_cnt per-output saturating count of contended grants
//
// Build option
//   LIB_SWITCH_CONFLICT_STATS_EN : when defined, o_conflict_cnt[j] counts edges on which
//   output j granted while two or more inputs requested it (saturating, cleared only by
//   reset). When undefined, no counter registers exist and o_conflict_cnt reads 0.

module lib_switch_onehot_rr #(
    parameter int N      = 4,
    parameter int M      = 4,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [0:N-1][DATA_W-1:0]    i_data,
    input  logic [0:N-1]                i_valid,
    input  logic [0:N-1][0:M-1]         i_dest,
    output logic [0:N-1]                o_ack,
    output logic [0:M-1][DATA_W-1:0]    o_data,
    output logic [0:M-1]                o_valid,
    input  logic [0:M-1]                i_en,
    output logic [0:M-1][CNT_W-1:0]     o_conflict_cnt
);

    localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------

    // Advance an input index by one, wrapping from N-1 back to 0. Works for
    // non-power-of-two N, where plain binary overflow would not wrap correctly.
    function automatic logic [PTR_W-1:0] f_wrap_inc(input logic [PTR_W-1:0] p);
        logic [PTR_W-1:0] r;
        if (p == PTR_W'(N - 1)) begin
            r = '0;
        end else begin
            r = p + PTR_W'(1);
        end
        return r;
    endfunction

    // Round-robin search starting at ptr. Returns {found, index}. The candidate
    // walks ptr, ptr+1, ... with wrap, and the first requester found wins.
    function automatic logic [PTR_W:0] f_arb(
        input logic [0:N-1]       req,
        input logic [PTR_W-1:0]   ptr
    );
        logic [PTR_W-1:0] cand;
        logic [PTR_W-1:0] win;
        logic             found;
        cand  = ptr;
        win   = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!found && req[cand]) begin
                found = 1'b1;
                win   = cand;
            end
            cand = f_wrap_inc(cand);
        end
        return {found, win};
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [0:M-1][DATA_W-1:0]  r_data;
    logic [0:M-1]              r_valid;
    logic [0:M-1][PTR_W-1:0]   r_ptr;

    // ------------------------------------------------------------------
    // Request matrix and load condition
    // ------------------------------------------------------------------
    logic [0:M-1][0:N-1]       w_req;       // w_req[j][i]: input i wants output j
    logic [0:M-1]              w_load_ok;   // output j can take a word this cycle
    logic [0:M-1]              w_gnt_vld;
    logic [0:M-1][PTR_W-1:0]   w_gnt_idx;

    always_comb begin
        w_req = '0;
        for (int j = 0; j < M; j++) begin
            for (int i = 0; i < N; i++) begin
                w_req[j][i] = i_valid[i] && i_dest[i][j];
            end
        end
    end

    // Loading while the old word is being consumed keeps full throughput.
    assign w_load_ok = ~r_valid | i_en;

    // ------------------------------------------------------------------
    // Per-output arbitration. Gating with reset keeps o_ack low while the
    // registers are held clear, since an empty output would otherwise grant.
    // ------------------------------------------------------------------
    always_comb begin
        logic [PTR_W:0] arb;
        w_gnt_vld = '0;
        w_gnt_idx = '0;
        arb       = '0;
        for (int j = 0; j < M; j++) begin
            arb = f_arb(w_req[j], r_ptr[j]);
            if (w_load_ok[j] && !reset) begin
                w_gnt_vld[j] = arb[PTR_W];
                w_gnt_idx[j] = arb[PTR_W-1:0];
            end
        end
    end

    // An input is acked if any output granted it. With a legal one-hot
    // request only one output can; a multi-hot request may collect several,
    // each output still loading that word at most once.
    always_comb begin
        o_ack = '0;
        for (int j = 0; j < M; j++) begin
            if (w_gnt_vld[j]) begin
                o_ack[w_gnt_idx[j]] = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output registers and round-robin pointers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_data  <= '0;
            r_valid <= '0;
            r_ptr   <= '0;
        end else begin
            for (int j = 0; j < M; j++) begin
                if (w_gnt_vld[j]) begin
                    r_data[j]  <= i_data[w_gnt_idx[j]];
                    r_valid[j] <= 1'b1;
                    // Winner moves to lowest priority on this output.
                    r_ptr[j]   <= f_wrap_inc(w_gnt_idx[j]);
                end else if (w_load_ok[j]) begin
                    // Drained (or already empty) with nothing to load: data is held.
                    r_valid[j] <= 1'b0;
                end
                // Stalled outputs hold everything.
            end
        end
    end

    assign o_data  = r_data;
    assign o_valid = r_valid;

    // ------------------------------------------------------------------
    // Optional contention statistics
    // ------------------------------------------------------------------
`ifdef LIB_SWITCH_CONFLICT_STATS_EN

    // True when two or more bits of req are set.
    function automatic logic f_multi(input logic [0:N-1] req);
        logic seen_one;
        logic seen_two;
        seen_one = 1'b0;
        seen_two = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (req[i]) begin
                if (seen_one) begin
                    seen_two = 1'b1;
                end
                seen_one = 1'b1;
            end
        end
        return seen_two;
    endfunction

    logic [0:M-1]              w_multi;
    logic [0:M-1][CNT_W-1:0]   r_cnt;

    always_comb begin
        w_multi = '0;
        for (int j = 0; j < M; j++) begin
            w_multi[j] = f_multi(w_req[j]);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else begin
            for (int j = 0; j < M; j++) begin
                // Saturate rather than wrap so a long run never reads as quiet.
                if (w_gnt_vld[j] && w_multi[j] && (r_cnt[j] != {CNT_W{1'b1}})) begin
                    r_cnt[j] <= r_cnt[j] + CNT_W'(1);
                end
            end
        end
    end

    assign o_conflict_cnt = r_cnt;

`else

    assign o_conflict_cnt = '0;

`endif

endmodule

// File: tb/tb_lib_switch_onehot_rr.sv
// Purpose : self-checking bench for lib_switch_onehot_rr (N=4, M=4, DATA_W=8, CNT_W=2).
// Latency : expects o_ack in the request cycle and output data one edge later.
// Backpr. : drives i_en randomly and in directed stalls; sources hold their word until acked.

module tb_lib_switch_onehot_rr;

    localparam int N      = 4;
    localparam int M      = 4;
    localparam int DATA_W = 8;
    localparam int CNT_W  = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic                       clk;
    logic                       reset;
    logic [0:N-1][DATA_W-1:0]   i_data;
    logic [0:N-1]               i_valid;
    logic [0:N-1][0:M-1]        i_dest;
    logic [0:N-1]               o_ack;
    logic [0:M-1][DATA_W-1:0]   o_data;
    logic [0:M-1]               o_valid;
    logic [0:M-1]               i_en;
    logic [0:M-1][CNT_W-1:0]    o_conflict_cnt;

    lib_switch_onehot_rr #(
        .N(N), .M(M), .DATA_W(DATA_W), .CNT_W(CNT_W)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .i_data         (i_data),
        .i_valid        (i_valid),
        .i_dest         (i_dest),
        .o_ack          (o_ack),
        .o_data         (o_data),
        .o_valid        (o_valid),
        .i_en           (i_en),
        .o_conflict_cnt (o_conflict_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // ---------------- reference model ----------------
    bit              m_valid [M];
    logic [7:0]      m_data  [M];
    int              m_ptr   [M];
    int              m_cnt   [M];
    int              g       [M];   // granted input per output, -1 if none
    int              nreq    [M];
    logic [0:N-1]    exp_ack;

    task automatic model_reset();
        for (int j = 0; j < M; j++) begin
            m_valid[j] = 0; m_data[j] = '0; m_ptr[j] = 0; m_cnt[j] = 0;
        end
    endtask

    // Arbitration for the current inputs: scan ptr, ptr+1, ... mod N.
    task automatic model_comb();
        exp_ack = '0;
        for (int j = 0; j < M; j++) begin
            g[j] = -1;
            nreq[j] = 0;
            for (int i = 0; i < N; i++)
                if (i_valid[i] && i_dest[i][j]) nreq[j]++;
            if (!reset && (!m_valid[j] || i_en[j])) begin
                for (int k = 0; k < N; k++) begin
                    int c;
                    c = (m_ptr[j] + k) % N;
                    if (g[j] < 0 && i_valid[c] && i_dest[c][j]) g[j] = c;
                end
            end
            if (g[j] >= 0) exp_ack[g[j]] = 1'b1;
        end
    endtask

    task automatic model_clk();
        for (int j = 0; j < M; j++) begin
            if (g[j] >= 0) begin
                m_data[j]  = i_data[g[j]];
                m_valid[j] = 1;
                m_ptr[j]   = (g[j] + 1) % N;
                if (nreq[j] >= 2 && m_cnt[j] < CNT_MAX) m_cnt[j]++;
            end else if (!m_valid[j] || i_en[j]) begin
                m_valid[j] = 0;
            end
        end
    endtask

    function automatic int exp_cnt(input int j);
`ifdef LIB_SWITCH_CONFLICT_STATS_EN
        return m_cnt[j];
`else
        return 0;
`endif
    endfunction

    // Inputs are changed at posedge+1; settle lets combinational o_ack resolve.
    task automatic settle();
        model_comb();
        #1;
    endtask

    task automatic advance();
        @(posedge clk);
        model_clk();
        #1;
    endtask

    task automatic clear_inputs();
        i_data = '0; i_valid = '0; i_dest = '0; i_en = '1;
    endtask

    task automatic reset_dut();
        reset = 1'b1;
        clear_inputs();
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset_dut();
        for (int c = 0; c < 10; c++) begin
            settle();
            n_cmp++;
            if (o_ack !== 4'b0000) begin
                n_bad++; $display("FAIL reset_idle_ack cyc=%0d got=%b exp=0000", c, o_ack);
            end
            advance();
            n_cmp++;
            if (o_valid !== 4'b0000 || o_data !== 32'h0) begin
                n_bad++; $display("FAIL reset_idle_out cyc=%0d valid=%b data=%h exp 0000/0", c, o_valid, o_data);
            end
        end
        // Load a word, then assert reset asynchronously mid-cycle.
        i_valid[0] = 1'b1; i_dest[0] = '0; i_dest[0][0] = 1'b1; i_data[0] = 8'h5C;
        settle();
        advance();
        n_cmp++;
        if (o_valid[0] !== 1'b1 || o_data[0] !== 8'h5C) begin
            n_bad++; $display("FAIL reset_preload valid=%b data=%h exp 1/5c", o_valid[0], o_data[0]);
        end
        reset = 1'b1;
        #1;
        n_cmp++;
        if (o_valid !== 4'b0000 || o_ack !== 4'b0000 || o_data !== 32'h0) begin
            n_bad++; $display("FAIL reset_async valid=%b ack=%b data=%h exp 0000/0000/0", o_valid, o_ack, o_data);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        clear_inputs();
        model_reset();
    endtask

    task automatic test_single_path();
        reset_dut();
        i_valid[2] = 1'b1; i_dest[2] = '0; i_dest[2][2] = 1'b1; i_data[2] = 8'hA5;
        settle();
        n_cmp++;
        if (o_ack !== 4'b0010) begin
            n_bad++; $display("FAIL single_ack got=%b exp=0010", o_ack);
        end
        advance();
        clear_inputs();
        n_cmp++;
        if (o_valid !== 4'b0010 || o_data[2] !== 8'hA5) begin
            n_bad++; $display("FAIL single_out valid=%b data2=%h exp 0010/a5", o_valid, o_data[2]);
        end
        settle();
        advance();
        n_cmp++;
        if (o_valid !== 4'b0000 || o_data[2] !== 8'hA5) begin
            n_bad++; $display("FAIL single_drain valid=%b data2=%h exp 0000/a5 held", o_valid, o_data[2]);
        end
    endtask

    task automatic test_fairness();
        int seq [6] = '{0, 1, 3, 0, 1, 3};
        int acks [N];
        reset_dut();
        for (int i = 0; i < N; i++) acks[i] = 0;
        foreach (seq[s]) begin end
        for (int i = 0; i < N; i++) begin
            if (i != 2) begin
                i_valid[i] = 1'b1; i_dest[i] = '0; i_dest[i][0] = 1'b1;
                i_data[i] = 8'(8'h10 * i + 1);
            end
        end
        for (int c = 0; c < 6; c++) begin
            logic [0:N-1] want;
            settle();
            want = '0; want[seq[c]] = 1'b1;
            n_cmp++;
            if (o_ack !== want) begin
                n_bad++; $display("FAIL fair_ack cyc=%0d got=%b exp=%b", c, o_ack, want);
            end
            for (int i = 0; i < N; i++) if (o_ack[i]) acks[i]++;
            advance();
            n_cmp++;
            if (o_valid[0] !== 1'b1 || o_data[0] !== m_data[0]) begin
                n_bad++; $display("FAIL fair_out cyc=%0d valid=%b data=%h exp 1/%h", c, o_valid[0], o_data[0], m_data[0]);
            end
            for (int i = 0; i < N; i++) if (exp_ack[i]) i_data[i] = 8'($urandom);
        end
        n_cmp++;
        if (acks[0] != 2 || acks[1] != 2 || acks[3] != 2 || acks[2] != 0) begin
            n_bad++; $display("FAIL fair_count got=%0d,%0d,%0d,%0d exp=2,2,0,2", acks[0], acks[1], acks[2], acks[3]);
        end
        clear_inputs();
    endtask

    task automatic test_ptr_wrap();
        reset_dut();
        i_valid[3] = 1'b1; i_dest[3] = '0; i_dest[3][1] = 1'b1; i_data[3] = 8'h33;
        settle();
        n_cmp++;
        if (o_ack !== 4'b0001) begin
            n_bad++; $display("FAIL wrap_first got=%b exp=0001", o_ack);
        end
        advance();
        i_data[3] = 8'h34;
        i_valid[0] = 1'b1; i_dest[0] = '0; i_dest[0][1] = 1'b1; i_data[0] = 8'h01;
        settle();
        n_cmp++;
        if (o_ack !== 4'b1000) begin
            n_bad++; $display("FAIL wrap_second got=%b exp=1000 (input 0 wins)", o_ack);
        end
        advance();
        n_cmp++;
        if (o_data[1] !== 8'h01) begin
            n_bad++; $display("FAIL wrap_data got=%h exp=01", o_data[1]);
        end
        clear_inputs();
    endtask

    task automatic test_backpressure();
        reset_dut();
        i_valid[0] = 1'b1; i_dest[0] = '0; i_dest[0][1] = 1'b1; i_data[0] = 8'h11;
        settle();
        advance();
        i_data[0] = 8'h22;
        i_en[1] = 1'b0;
        for (int c = 0; c < 5; c++) begin
            settle();
            n_cmp++;
            if (o_ack[0] !== 1'b0) begin
                n_bad++; $display("FAIL bp_ack cyc=%0d got=%b exp=0", c, o_ack[0]);
            end
            advance();
            n_cmp++;
            if (o_valid[1] !== 1'b1 || o_data[1] !== 8'h11) begin
                n_bad++; $display("FAIL bp_hold cyc=%0d valid=%b data=%h exp 1/11", c, o_valid[1], o_data[1]);
            end
        end
        i_en[1] = 1'b1;
        settle();
        n_cmp++;
        if (o_ack[0] !== 1'b1) begin
            n_bad++; $display("FAIL bp_release_ack got=%b exp=1", o_ack[0]);
        end
        advance();
        n_cmp++;
        if (o_valid[1] !== 1'b1 || o_data[1] !== 8'h22) begin
            n_bad++; $display("FAIL bp_release_data valid=%b data=%h exp 1/22", o_valid[1], o_data[1]);
        end
        clear_inputs();
    endtask

    task automatic test_conflict_stats();
        int want;
        reset_dut();
        for (int i = 0; i < 2; i++) begin
            i_valid[i] = 1'b1; i_dest[i] = '0; i_dest[i][3] = 1'b1; i_data[i] = 8'(i + 8'h70);
        end
        for (int c = 0; c < 4; c++) begin
            settle();
            advance();
            for (int i = 0; i < N; i++) if (exp_ack[i]) i_data[i] = 8'($urandom);
        end
`ifdef LIB_SWITCH_CONFLICT_STATS_EN
        want = 3;
`else
        want = 0;
`endif
        n_cmp++;
        if (int'(o_conflict_cnt[3]) != want) begin
            n_bad++; $display("FAIL conflict_sat got=%0d exp=%0d", o_conflict_cnt[3], want);
        end
        clear_inputs();
        i_valid[2] = 1'b1; i_dest[2] = '0; i_dest[2][3] = 1'b1; i_data[2] = 8'h99;
        settle();
        advance();
        n_cmp++;
        if (int'(o_conflict_cnt[3]) != want || o_data[3] !== 8'h99) begin
            n_bad++; $display("FAIL conflict_single cnt=%0d data=%h exp %0d/99", o_conflict_cnt[3], o_data[3], want);
        end
        clear_inputs();
    endtask

    task automatic test_random();
        reset_dut();
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                // A pending source keeps its word; an idle one may start a new one.
                if (!i_valid[i] && ($urandom_range(0, 2) != 0)) begin
                    i_valid[i] = 1'b1;
                    i_data[i]  = 8'($urandom);
                    i_dest[i]  = '0;
                    if ($urandom_range(0, 7) != 0) i_dest[i][$urandom_range(0, M - 1)] = 1'b1;
                end
            end
            for (int j = 0; j < M; j++) i_en[j] = ($urandom_range(0, 3) != 0);
            settle();
            n_cmp++;
            if (o_ack !== exp_ack) begin
                n_bad++; $display("FAIL rand_ack cyc=%0d got=%b exp=%b", c, o_ack, exp_ack);
            end
            advance();
            for (int j = 0; j < M; j++) begin
                n_cmp++;
                if (o_valid[j] !== m_valid[j] || o_data[j] !== m_data[j] ||
                    int'(o_conflict_cnt[j]) != exp_cnt(j)) begin
                    n_bad++;
                    $display("FAIL rand_out cyc=%0d j=%0d valid=%b data=%h cnt=%0d exp %b/%h/%0d",
                             c, j, o_valid[j], o_data[j], o_conflict_cnt[j], m_valid[j], m_data[j], exp_cnt(j));
                end
            end
            for (int i = 0; i < N; i++)
                if (exp_ack[i] || i_dest[i] == '0) i_valid[i] = 1'b0;
        end
        clear_inputs();
    endtask

    initial begin
        reset = 1'b1;
        clear_inputs();
        test_reset();
        test_single_path();
        test_fairness();
        test_ptr_wrap();
        test_backpressure();
        test_conflict_stats();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule
